// File: rtl/version_store.sv
// -----------------------------------------------------------------------------
// version_store
//
// Multi-version write-once buffer. Each accepted write receives the next
// version number (1, 2, 3, ...) and is stored in slot (version-1). All slots
// are presented in parallel as flattened version and data buses. The
// currentVersion output is the latest assigned version (0 = none). A reader
// asks for the newest entry with readVersion = currentVersion + 1.
// A clear pulse retires every version and restarts numbering at 1.
//
// Parameters:
//   DATA_WIDTH    width of one data entry
//   VERSION_WIDTH width of one version tag (needs VERSION_NUM <= 2^VERSION_WIDTH-1)
//   VERSION_NUM   number of slots (maximum live versions)
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset, highest priority
//   wrValid         write request
//   wrReady         store can accept a write this cycle (combinational)
//   wrData          data for the write
//   clear           single-cycle pulse retiring all versions
//   versions        slot k tag at [k*VERSION_WIDTH +: VERSION_WIDTH], 0 = empty
//   dataInputs      slot k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   currentVersion  latest assigned version, 0 = none
//   full            all slots written (registered, high exactly in FULL)
//   wrVersion       version the next accepted write receives (currentVersion+1)
//
// Optional feature, enabled by defining VERSION_STORE_DROP_STATS_EN:
//   dropCount  [15:0] saturating count of cycles with wrValid=1 and wrReady=0
//   overflow   [0:0]  sticky flag, set when wrValid=1 while FULL
//   Both are cleared by rst only; clear leaves them untouched.
// -----------------------------------------------------------------------------
module version_store #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wrValid,
    output logic                                 wrReady,
    input  logic [DATA_WIDTH-1:0]                wrData,
    input  logic                                 clear,
    output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
    output logic [DATA_WIDTH*VERSION_NUM-1:0]    dataInputs,
    output logic [VERSION_WIDTH-1:0]             currentVersion,
    output logic                                 full,
    output logic [VERSION_WIDTH-1:0]             wrVersion
`ifdef VERSION_STORE_DROP_STATS_EN
    ,
    output logic [15:0]                          dropCount,
    output logic [0:0]                           overflow
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;

    state_t                   state_reg;
    logic [VERSION_WIDTH-1:0] current_version_reg;
    logic                     full_reg;
    logic                     accept;
    logic [VERSION_WIDTH-1:0] next_version;

    // Writes are only taken while slots remain and no clear is in progress
    // or being requested; clear always wins over a simultaneous write.
    assign wrReady = ((state_reg == ST_EMPTY) || (state_reg == ST_FILLING)) && !clear;
    assign accept  = wrValid && wrReady;

    // Wraps at VERSION_WIDTH bits; while FULL it reads VERSION_NUM+1 and is
    // informational only, because no write can be accepted in that state.
    assign next_version = current_version_reg + VERSION_WIDTH'(1);

    assign wrVersion      = next_version;
    assign currentVersion = current_version_reg;
    assign full           = full_reg;

    // -------------------------------------------------------------------------
    // Control FSM with registered currentVersion and full
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= ST_EMPTY;
            current_version_reg <= '0;
            full_reg            <= 1'b0;
        end else if (clear) begin
            // Also covers clear while already in CLEAR: stay one more cycle.
            state_reg           <= ST_CLEAR;
            current_version_reg <= '0;
            full_reg            <= 1'b0;
        end else begin
            case (state_reg)
                ST_EMPTY, ST_FILLING: begin
                    if (accept) begin
                        current_version_reg <= next_version;
                        if (next_version == VERSION_WIDTH'(VERSION_NUM)) begin
                            state_reg <= ST_FULL;
                            full_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_FILLING;
                        end
                    end
                end
                ST_FULL: begin
                    // Held until clear or reset; writes are refused here.
                    state_reg <= ST_FULL;
                end
                ST_CLEAR: begin
                    state_reg <= ST_EMPTY;
                end
                default: begin
                    state_reg <= ST_EMPTY;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Slot storage. Every slot is visible on the output buses at once, so the
    // slots are plain registers rather than a memory array. A slot is written
    // exactly once: when the accepted write's version equals its index + 1.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < VERSION_NUM; gi++) begin : g_slot
            logic [VERSION_WIDTH-1:0] tag_reg;
            logic [DATA_WIDTH-1:0]    data_reg;
            logic                     slot_write;

            // currentVersion == gi means the incoming version is gi+1.
            assign slot_write = accept && (current_version_reg == VERSION_WIDTH'(gi));

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    tag_reg  <= '0;
                    data_reg <= '0;
                end else if (slot_write) begin
                    tag_reg  <= VERSION_WIDTH'(gi + 1);
                    data_reg <= wrData;
                end
            end

            assign versions[gi*VERSION_WIDTH +: VERSION_WIDTH] = tag_reg;
            assign dataInputs[gi*DATA_WIDTH +: DATA_WIDTH]     = data_reg;
        end
    endgenerate

`ifdef VERSION_STORE_DROP_STATS_EN
    // -------------------------------------------------------------------------
    // Drop statistics; survive clear, reset only by rst.
    // -------------------------------------------------------------------------
    logic [15:0] drop_count_reg;
    logic        overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (wrValid && !wrReady && (drop_count_reg != 16'hFFFF)) begin
                drop_count_reg <= drop_count_reg + 16'd1;
            end
            if (wrValid && (state_reg == ST_FULL)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign dropCount = drop_count_reg;
    assign overflow  = overflow_reg;
`endif

endmodule

// File: tb/tb_version_store.sv
// -----------------------------------------------------------------------------
// tb_version_store
//
// Self-checking bench for version_store. A reference model tracks the store
// as "number of versions written" plus a list of stored data words and a
// one-cycle clearing flag; expected buses are rebuilt from that every cycle.
// Directed sequences follow the intended use cases, then a randomized phase
// mixes writes, clears and resets.
// -----------------------------------------------------------------------------
module tb_version_store;

    localparam int DW  = 32;
    localparam int VW  = 4;
    localparam int NUM = 4;
    localparam int CW  = 128;

    logic                clk = 1'b0;
    logic                rst;
    logic                wrValid;
    logic                wrReady;
    logic [DW-1:0]       wrData;
    logic                clear;
    logic [VW*NUM-1:0]   versions;
    logic [DW*NUM-1:0]   dataInputs;
    logic [VW-1:0]       currentVersion;
    logic                full;
    logic [VW-1:0]       wrVersion;
`ifdef VERSION_STORE_DROP_STATS_EN
    logic [15:0]         dropCount;
    logic [0:0]          overflow;
`endif

    version_store #(
        .DATA_WIDTH   (DW),
        .VERSION_WIDTH(VW),
        .VERSION_NUM  (NUM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wrValid       (wrValid),
        .wrReady       (wrReady),
        .wrData        (wrData),
        .clear         (clear),
        .versions      (versions),
        .dataInputs    (dataInputs),
        .currentVersion(currentVersion),
        .full          (full),
        .wrVersion     (wrVersion)
`ifdef VERSION_STORE_DROP_STATS_EN
        ,
        .dropCount     (dropCount),
        .overflow      (overflow)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int            m_n;          // versions currently stored
    bit            m_in_clear;   // one cycle of retirement after a clear
    bit            m_known;      // model valid once reset has been applied
    logic [DW-1:0] m_data [NUM];
    int            m_drops;
    bit            m_ovf;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_ready(input logic c);
        return !m_in_clear && (m_n < NUM) && !c;
    endfunction

    function automatic logic [VW*NUM-1:0] m_versions();
        logic [VW*NUM-1:0] r = '0;
        for (int k = 0; k < NUM; k++)
            if (k < m_n) r[k*VW +: VW] = VW'(k + 1);
        return r;
    endfunction

    function automatic logic [DW*NUM-1:0] m_datas();
        logic [DW*NUM-1:0] r = '0;
        for (int k = 0; k < NUM; k++)
            if (k < m_n) r[k*DW +: DW] = m_data[k];
        return r;
    endfunction

    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic c, input logic r);
        logic rdy;
        rdy = m_ready(c);
        if (r) begin
            m_n = 0; m_in_clear = 0; m_drops = 0; m_ovf = 0; m_known = 1;
        end else begin
            if (v && !rdy && m_drops < 65535) m_drops++;
            if (v && !m_in_clear && m_n == NUM) m_ovf = 1;
            if (c) begin
                m_n = 0; m_in_clear = 1;
            end else if (m_in_clear) begin
                m_in_clear = 0;
            end else if (v && rdy) begin
                m_data[m_n] = d;
                m_n++;
            end
        end
    endtask

    // One clock cycle: drive inputs away from the edge, check the
    // combinational ready, advance the model, then check registered outputs.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic c, input logic r);
        @(negedge clk);
        wrValid = v; wrData = d; clear = c; rst = r;
        #1;
        if (m_known) check("wrReady", CW'(wrReady), CW'(m_ready(c)));
        model_edge(v, d, c, r);
        @(posedge clk);
        #1;
        check("versions",       CW'(versions),       CW'(m_versions()));
        check("dataInputs",     CW'(dataInputs),     CW'(m_datas()));
        check("currentVersion", CW'(currentVersion), CW'(m_n));
        check("full",           CW'(full),           CW'(m_n == NUM));
        check("wrVersion",      CW'(wrVersion),      CW'(VW'(m_n + 1)));
`ifdef VERSION_STORE_DROP_STATS_EN
        check("dropCount",      CW'(dropCount),      CW'(m_drops));
        check("overflow",       CW'(overflow),       CW'(m_ovf));
`endif
    endtask

    initial begin
        m_n = 0; m_in_clear = 0; m_known = 0; m_drops = 0; m_ovf = 0;
        rst = 1'b1; wrValid = 1'b0; wrData = '0; clear = 1'b0;

        // Reset then idle
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("idle_versions", CW'(versions), CW'(16'h0000));
        check("idle_wrReady",  CW'(wrReady),  CW'(1'b1));
        check("idle_wrVersion", CW'(wrVersion), CW'(4'd1));

        // Four back-to-back writes
        step(1, 32'hA0, 0, 0);
        check("step_cv1", CW'(currentVersion), CW'(4'd1));
        step(1, 32'hB1, 0, 0);
        check("step_cv2", CW'(currentVersion), CW'(4'd2));
        step(1, 32'hC2, 0, 0);
        check("step_cv3", CW'(currentVersion), CW'(4'd3));
        step(1, 32'hD3, 0, 0);
        check("fill_versions", CW'(versions), CW'(16'h4321));
        check("fill_data", CW'(dataInputs), {32'hD3, 32'hC2, 32'hB1, 32'hA0});
        check("fill_full", CW'(full), CW'(1'b1));
        check("fill_ready", CW'(wrReady), CW'(1'b0));

        // Writes while full are ignored
        for (int i = 0; i < 3; i++) step(1, 32'hEE, 0, 0);
        check("ovf_versions", CW'(versions), CW'(16'h4321));
        check("ovf_cv", CW'(currentVersion), CW'(4'd4));
`ifdef VERSION_STORE_DROP_STATS_EN
        check("ovf_dropCount", CW'(dropCount), CW'(16'd3));
        check("ovf_overflow", CW'(overflow), CW'(1'b1));
`endif

        // Two writes then clear together with wrValid, then write again
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        step(1, 32'h33, 1, 0);
        check("clr_versions", CW'(versions), CW'(16'h0000));
        check("clr_ready", CW'(wrReady), CW'(1'b0));
        step(0, 0, 0, 0);
        step(1, 32'h44, 0, 0);
        check("after_clr_versions", CW'(versions), CW'(16'h0001));
        check("after_clr_data0", CW'(dataInputs[31:0]), CW'(32'h44));

        // wrValid held high through CLEAR: accepted only on first EMPTY cycle
        step(0, 0, 1, 0);
        step(1, 32'h55, 0, 0);
        step(1, 32'h66, 0, 0);
        check("gated_cv", CW'(currentVersion), CW'(4'd1));
        check("gated_data0", CW'(dataInputs[31:0]), CW'(32'h66));

        // Reset during FILLING with a write pending
        step(1, 32'h77, 0, 0);
        step(1, 32'h88, 0, 1);
        check("rst_versions", CW'(versions), CW'(16'h0000));
        check("rst_cv", CW'(currentVersion), CW'(4'd0));
`ifdef VERSION_STORE_DROP_STATS_EN
        check("rst_dropCount", CW'(dropCount), CW'(16'd0));
`endif

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 $urandom(),
                 ($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/version_store.md
Name: version_store

Overview:
- Multi-version write-once buffer feeding the priority router's `versions` and `dataInputs` buses.
- Each accepted write gets the next version number (1, 2, 3, ...) and is stored in slot (version-1).
- The store presents flattened version/data buses and the current (latest) version, so a reader issues readVersion = currentVersion+1 to get the newest entry.
- A clear pulse retires all versions and restarts numbering at 1.

Parameters:
- DATA_WIDTH, 32, width of one data entry.
- VERSION_WIDTH, 4, width of one version tag. Legal only if VERSION_NUM <= 2^VERSION_WIDTH-1.
- VERSION_NUM, 4, number of slots (maximum live versions).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wrValid  input  1  write request.
- wrReady  output  1  store can accept a write this cycle.
- wrData  input  DATA_WIDTH  data for the write.
- clear  input  1  single-cycle pulse that retires all versions.
- versions  output  VERSION_WIDTH*VERSION_NUM  slot k tag at bits [k*VERSION_WIDTH +: VERSION_WIDTH]; 0 = empty slot.
- dataInputs  output  DATA_WIDTH*VERSION_NUM  slot k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
- currentVersion  output  VERSION_WIDTH  latest assigned version; 0 = none.
- full  output  1  all slots written.
- wrVersion  output  VERSION_WIDTH  version the next accepted write will receive (currentVersion+1).

Behaviour:
- Reset: all of the following are 0 one cycle after rst is sampled high; state is EMPTY; wrReady = 1 after reset.
  - versions, dataInputs, currentVersion, full.
- rst has priority over every other input, including mid-fill and mid-CLEAR.
- FSM states: EMPTY, FILLING, FULL, CLEAR.
- wrReady is combinational:
  - 1 in EMPTY or FILLING with clear = 0.
  - 0 in FULL or CLEAR, or whenever clear = 1.
- A write is accepted when wrValid && wrReady. On the next edge:
  - v = currentVersion+1.
  - versions slot (v-1) <= v.
  - dataInputs slot (v-1) <= wrData.
  - currentVersion <= v.
  - Single-cycle latency: new values are visible the cycle after acceptance.
- Written slots are never modified until clear or reset. Unwritten slots stay 0.
- Transitions:
  - EMPTY -> FILLING on an accepted write when VERSION_NUM > 1.
  - EMPTY -> FULL on an accepted write when VERSION_NUM = 1.
  - FILLING -> FULL when the accepted write has v == VERSION_NUM.
  - full = 1 exactly in state FULL, registered.
  - Any of EMPTY/FILLING/FULL -> CLEAR when clear = 1.
  - CLEAR -> EMPTY unconditionally after one cycle.
- clear sampled high: on the next edge, all of the following are zeroed together and the FSM enters CLEAR.
  - versions, dataInputs, currentVersion, full.
- clear and wrValid high in the same cycle: the write is not accepted (wrReady = 0) and clear wins.
- clear high while in CLEAR: stay in CLEAR one more cycle; buses remain 0.
- wrValid held in FULL: no state change, wrData ignored, no wraparound of version numbers.
- wrVersion = currentVersion+1, computed at VERSION_WIDTH bits. It is VERSION_NUM+1 while full; this value is informational only.
- wrData is ignored whenever no write is accepted.

Optional Feature:
- Macro: VERSION_STORE_DROP_STATS_EN.
- Defined:
  - Adds output dropCount [15:0], which increments (saturating at 16'hFFFF) every cycle wrValid = 1 and wrReady = 0.
  - Adds output overflow [0:0], sticky; set when wrValid = 1 in state FULL.
  - Both are cleared by rst only, not by clear.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset then idle -> versions = 16'h0000, dataInputs = 0, currentVersion = 0, full = 0, wrReady = 1, wrVersion = 1.
- Four back-to-back writes of A0, B1, C2, D3 -> after the 4th edge:
  - versions = 16'h4321, dataInputs = {D3,C2,B1,A0}, currentVersion = 4, full = 1, wrReady = 0.
  - Each intermediate cycle currentVersion steps 1, 2, 3.
- Full, then wrValid = 1 with wrData = EE for 3 cycles -> buses unchanged, currentVersion = 4. With the macro: dropCount = 3, overflow = 1.
- Two writes, then clear = 1 together with wrValid = 1 ->
  - no write accepted;
  - next cycle the state is CLEAR, all buses 0, wrReady = 0;
  - cycle after that the state is EMPTY, and the next write lands in slot 0 with version 1.
- Write gated by wrReady during CLEAR: wrValid held high through CLEAR -> accepted only on the first EMPTY cycle, currentVersion = 1.
- Assert rst during FILLING (currentVersion = 2) while wrValid = 1 -> next cycle everything is 0, the write is not stored, and dropCount = 0 if the macro is defined.
